// File: rtl/mem_port_arbiter_if.sv
// Bundle between the shared-RAM arbiter, the IF/MEM stages and the RAM.
// slave: arbiter side; master: the stages and RAM that drive it.
interface mem_port_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ready_o;
  logic [31:0] if_rdata_o;
  logic        mem_req_i;
  logic        mem_write_i;
  logic [1:0]  mem_width_i;
  logic        mem_sign_extend_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_ready_o;
  logic [31:0] mem_rdata_o;
  logic        mem_misaligned_o;
  logic        ram_req_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_wdata_o;
  logic        ram_ack_i;
  logic [31:0] ram_rdata_i;
  logic        stall_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  mem_req_i, mem_write_i, mem_width_i,
    input  mem_sign_extend_i, mem_addr_i, mem_wdata_i,
    input  ram_ack_i, ram_rdata_i,
    output if_ready_o, if_rdata_o,
    output mem_ready_o, mem_rdata_o, mem_misaligned_o,
    output ram_req_o, ram_we_o, ram_addr_o,
    output ram_be_o, ram_wdata_o, stall_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output mem_req_i, mem_write_i, mem_width_i,
    output mem_sign_extend_i, mem_addr_i, mem_wdata_i,
    output ram_ack_i, ram_rdata_i,
    input  if_ready_o, if_rdata_o,
    input  mem_ready_o, mem_rdata_o, mem_misaligned_o,
    input  ram_req_o, ram_we_o, ram_addr_o,
    input  ram_be_o, ram_wdata_o, stall_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between fetch and data, data first,
// with a starvation bound for fetch. Ports: clk, rst_n, bus (slave).
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, DATA, INSTR, DONE_D, DONE_I
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [3:0]  starve_q;
  logic        fetch_win, data_win;
  logic        acked;

  logic [1:0]  off;
  logic        byte_w, half_w, word_w;
  logic        misal;
  logic [3:0]  be_d;
  logic [31:0] wd_d;

  logic        ram_req_q, ram_we_q;
  logic [31:0] ram_addr_q, ram_wdata_q;
  logic [3:0]  ram_be_q;
  logic        if_ready_q, mem_ready_q, mis_q;
  logic [31:0] if_rdata_q, mem_rdata_q;

  logic [1:0]  wid_q, off_q;
  logic        sext_q;
  logic [31:0] sh, ld;

  assign off    = bus.mem_addr_i[1:0];
  assign byte_w = bus.mem_width_i == 2'd0;
  assign half_w = bus.mem_width_i == 2'd1;
  assign word_w = bus.mem_width_i[1];
  assign misal  = (half_w & off[0])
                | (word_w & (off != 2'd0));

  always_comb begin
    state_d   = state_q;
    fetch_win = 1'b0;
    data_win  = 1'b0;
    acked     = 1'b0;
    unique case (state_q)
      IDLE: begin
        fetch_win = bus.if_req_i
                  & (~bus.mem_req_i | (starve_q == LIMIT));
        data_win  = ~fetch_win & bus.mem_req_i;
        if (fetch_win)
          state_d = INSTR;
        else if (data_win)
          state_d = misal ? DONE_D : DATA;
      end
      DATA: begin
        acked = bus.ram_ack_i;
        if (bus.ram_ack_i) state_d = DONE_D;
      end
      INSTR: begin
        acked = bus.ram_ack_i;
        if (bus.ram_ack_i) state_d = DONE_I;
      end
      DONE_D:  state_d = IDLE;
      DONE_I:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    be_d = 4'hF;
    wd_d = bus.mem_wdata_i;
    unique case (1'b1)
      byte_w: begin
        be_d = 4'b0001 << off;
        wd_d = {4{bus.mem_wdata_i[7:0]}};
      end
      half_w: begin
        be_d = 4'b0011 << off;
        wd_d = {2{bus.mem_wdata_i[15:0]}};
      end
      word_w: begin
        be_d = 4'hF;
        wd_d = bus.mem_wdata_i;
      end
    endcase
  end

  assign sh = bus.ram_rdata_i >> {off_q, 3'b000};

  always_comb begin
    ld = bus.ram_rdata_i;
    unique case (1'b1)
      wid_q == 2'd0:
        ld = {{24{sext_q & sh[7]}}, sh[7:0]};
      wid_q == 2'd1:
        ld = {{16{sext_q & sh[15]}}, sh[15:0]};
      wid_q[1]:
        ld = bus.ram_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= 4'd0;
    end else begin
      state_q <= state_d;
      if (fetch_win)
        starve_q <= 4'd0;
      else if (data_win & bus.if_req_i
               & (starve_q != LIMIT))
        starve_q <= starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_be_q    <= '0;
      ram_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      mis_q       <= 1'b0;
      wid_q       <= '0;
      off_q       <= '0;
      sext_q      <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      mis_q       <= 1'b0;
      if (fetch_win) begin
        ram_req_q  <= 1'b1;
        ram_we_q   <= 1'b0;
        ram_be_q   <= 4'hF;
        ram_addr_q <= bus.if_addr_i & 32'hFFFF_FFFC;
      end
      if (data_win) begin
        if (misal) begin
          mem_ready_q <= 1'b1;
          mis_q       <= 1'b1;
        end else begin
          ram_req_q   <= 1'b1;
          ram_we_q    <= bus.mem_write_i;
          ram_be_q    <= be_d;
          ram_wdata_q <= wd_d;
          ram_addr_q  <= bus.mem_addr_i & 32'hFFFF_FFFC;
          wid_q       <= bus.mem_width_i;
          off_q       <= off;
          sext_q      <= bus.mem_sign_extend_i;
        end
      end
      if (acked) begin
        ram_req_q <= 1'b0;
        if (state_q == DATA) begin
          mem_ready_q <= 1'b1;
          mem_rdata_q <= ld;
        end else begin
          if_ready_q <= 1'b1;
          if_rdata_q <= bus.ram_rdata_i;
        end
      end
    end
  end

  assign bus.ram_req_o        = ram_req_q;
  assign bus.ram_we_o         = ram_we_q;
  assign bus.ram_addr_o       = ram_addr_q;
  assign bus.ram_be_o         = ram_be_q;
  assign bus.ram_wdata_o      = ram_wdata_q;
  assign bus.if_ready_o       = if_ready_q;
  assign bus.if_rdata_o       = if_rdata_q;
  assign bus.mem_ready_o      = mem_ready_q;
  assign bus.mem_rdata_o      = mem_rdata_q;
  assign bus.mem_misaligned_o = mis_q;
  assign bus.stall_o =
      (bus.mem_req_i & ~mem_ready_q)
    | (bus.if_req_i & ~if_ready_q);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port instruction/data RAM between the IF stage (instruction fetch) and the MEM stage, which is driven by the EX/MEM pipeline register. Requests from both stages are arbitrated, sub-word data accesses are converted to byte-lane RAM cycles, and results are returned with a one-cycle ready pulse. A pipeline stall is raised while either stage waits. Data requests have priority, and a bounded-starvation counter protects instruction fetch.

## Interface
- STARVE_LIMIT, default 4: maximum number of consecutive data grants allowed while a fetch is pending. Legal range is 1–15.
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request; held stable until if_ready_o.
- if_addr_i  in  32  fetch address; must be word-aligned.
- if_ready_o  out  1  one-cycle pulse: fetch complete.
- if_rdata_o  out  32  fetched word; valid while if_ready_o is high.
- mem_req_i  in  1  data request (load or store); held stable until mem_ready_o.
- mem_write_i  in  1  1 = store, 0 = load.
- mem_width_i  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
- mem_sign_extend_i  in  1  load extension select: 1 = sign-extend, 0 = zero-extend.
- mem_addr_i  in  32  byte address (the ALU result).
- mem_wdata_i  in  32  store data; value is in the low bits.
- mem_ready_o  out  1  one-cycle pulse: data access complete.
- mem_rdata_o  out  32  extended load data; valid with mem_ready_o.
- mem_misaligned_o  out  1  pulses together with mem_ready_o when the access was misaligned.
- ram_req_o  out  1  RAM request; held until ram_ack_i.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  32  word address: the byte address with bits [1:0] forced to 0.
- ram_be_o  out  4  byte-lane enables.
- ram_wdata_o  out  32  lane-replicated store data.
- ram_ack_i  in  1  RAM completion; for reads, ram_rdata_i is valid in the same cycle.
- ram_rdata_i  in  32  RAM read word.
- stall_o  out  1  combinational: (mem_req_i & ~mem_ready_o) | (if_req_i & ~if_ready_o).

## Operation
- Reset values: all outputs 0, state IDLE, starve counter 0.
- FSM states:
  - IDLE → DATA, when the data request wins.
  - IDLE → INSTR, when the fetch request wins.
  - DATA → DONE_D, on ram_ack_i.
  - INSTR → DONE_I, on ram_ack_i.
  - DONE_D → IDLE and DONE_I → IDLE, unconditionally.
- Arbitration, evaluated in IDLE only:
  - The fetch wins if if_req_i is high and either (a) mem_req_i is low, or (b) the starve counter equals STARVE_LIMIT.
  - Otherwise the data request wins if mem_req_i is high.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on a data grant made while if_req_i is high.
  - Clears on a fetch grant.
  - Holds on a data grant made while if_req_i is low.
- On grant, ram_addr_o, ram_we_o, ram_be_o and ram_wdata_o are registered. ram_req_o rises in the next cycle and stays high until the cycle in which ram_ack_i is sampled high.
- Byte lanes, with off = addr[1:0]:
  - byte: be = 1<<off.
  - half: be = 3<<off.
  - word: be = 4'hF.
  - Fetches use be = 4'hF and we = 0.
- Store data replication:
  - byte: wdata = {4{wdata[7:0]}}.
  - half: wdata = {2{wdata[15:0]}}.
  - word: passed unchanged.
- Load data: the selected lane is shifted down by 8*off and then sign- or zero-extended according to mem_sign_extend_i and the width.
- Misaligned accesses are a half-word with off[0]=1, or a word with off≠0. They make no RAM cycle: the grant goes directly to DONE_D with mem_misaligned_o = 1, mem_rdata_o = 0, and no write.
- DONE_x states:
  - x_ready_o is 1 and x_rdata_o is registered from the RAM.
  - Ready and rdata clear on the next edge.
  - The DONE cycle prevents a second issue on a request that is still held high.

## Timing
- A request sampled in IDLE at cycle T is granted at T.
- ram_req_o is high from T+1.
- With ack at cycle A ≥ T+1, ready pulses at A+1 and the FSM is back in IDLE at A+2. The earliest next grant is A+2.
- Zero-wait RAM: one access every 3 cycles. Misaligned access: ready at T+1.
- Simultaneous requests in IDLE resolve by the arbitration rule. The loser waits with stall_o high.
- A request that deasserts while it is not granted is dropped silently. A request that deasserts after its grant is still completed.
- ram_ack_i outside the DATA and INSTR states is ignored.
- Reset asserted mid-access: the FSM returns immediately to IDLE, ram_req_o drops asynchronously, and no ready pulse is produced. The RAM must tolerate an abandoned request.

## Test plan
- Word load, zero wait: mem_req=1 at addr 0x100; RAM returns 0xDEADBEEF with ack in the first req cycle. Required: ram_be=F, mem_ready pulse exactly 2 cycles after grant, mem_rdata=0xDEADBEEF, stall_o high until the ready cycle.
- Byte load, sign-extend: addr 0x103, width 0, sext=1; RAM word 0x80FF_0000. Required: be=4'b1000, mem_rdata=0xFFFFFF80. Repeat with sext=0: mem_rdata=0x00000080.
- Half store: addr 0x202, wdata 0x1234ABCD, width 1. Required: be=4'b1100, ram_wdata=0xABCDABCD, we=1, ram_addr=0x200.
- Starvation: STARVE_LIMIT=4, if_req and mem_req held high continuously. Required: grant order is D,D,D,D,I,D,D,D,D,I; the counter clears on each fetch grant.
- Misaligned word load: addr 0x101. Required: ram_req never rises, mem_ready and mem_misaligned pulse at T+1, mem_rdata=0.
- Reset mid-access: rst_n low while in DATA with ack not yet given. Required: ram_req_o=0 immediately, no ready pulse, all outputs 0. A request presented after release starts a fresh grant.
